tjrpu_mem_arbiter: RTL and testbench

Shares the single-port program/data memory of the tjrpu core between two requesters: the Caravel management Wishbone slave port (host) and the tjrpu core's load/store/fetch port (core). Each granted access is sequenced to the memory with a fixed read latency, and the response is returned to the winning requester. Contention is resolved by round-robin. The block sits inside the user project between the wbs_* pins and the memory macro.

---
 rtl/tjrpu_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_tjrpu_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tjrpu_mem_arbiter.sv
// rtl/tjrpu_mem_arbiter.sv - round-robin arbiter sharing the tjrpu memory between Wishbone host and core
module tjrpu_mem_arbiter #(
   parameter int ADDR_W  = 10,
   parameter int MEM_LAT = 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [3:0]        core_sel_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [31:0]       core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [31:0]       core_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_wmask_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic       owner_q;       // 1 = core owns the current access
   logic       last_grant_q;  // 1 = core was granted last
   logic       host_abort_q;
   logic [1:0] cnt_q;
   logic       host_req;
   logic       grant_core;
   logic       wait_done;
   logic       unused_adr;

   assign host_req   = wbs_cyc_i & wbs_stb_i;
   assign wait_done  = (cnt_q == LAST_CNT);
   assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      grant_core = core_req_i;
      if (host_req && core_req_i) begin
         grant_core = ~last_grant_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (host_req || core_req_i) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (wait_done) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         host_abort_q  <= 1'b0;
         cnt_q         <= '0;
         wbs_ack_o     <= 1'b0;
         wbs_dat_o     <= '0;
         core_gnt_o    <= 1'b0;
         core_rvalid_o <= 1'b0;
         core_rdata_o  <= '0;
         mem_en_o      <= 1'b0;
         mem_we_o      <= 1'b0;
         mem_wmask_o   <= '0;
         mem_addr_o    <= '0;
         mem_wdata_o   <= '0;
      end else begin
         mem_en_o      <= 1'b0;
         core_gnt_o    <= 1'b0;
         wbs_ack_o     <= 1'b0;
         core_rvalid_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (host_req || core_req_i) begin
                  owner_q      <= grant_core;
                  host_abort_q <= 1'b0;
                  mem_en_o     <= 1'b1;
                  core_gnt_o   <= grant_core;
                  if (grant_core) begin
                     mem_we_o    <= core_we_i;
                     mem_wmask_o <= core_sel_i;
                     mem_addr_o  <= core_addr_i;
                     mem_wdata_o <= core_wdata_i;
                  end else begin
                     mem_we_o    <= wbs_we_i;
                     mem_wmask_o <= wbs_sel_i;
                     mem_addr_o  <= wbs_adr_i[ADDR_W+1:2];
                     mem_wdata_o <= wbs_dat_i;
                  end
               end
            end
            ISSUE: begin
               last_grant_q <= owner_q;
               cnt_q        <= '0;
               if (!owner_q && !wbs_cyc_i) host_abort_q <= 1'b1;
            end
            WAIT: begin
               cnt_q <= wait_done ? 2'd0 : cnt_q + 2'd1;
               if (!owner_q && !wbs_cyc_i) host_abort_q <= 1'b1;
               // Response is registered here so it appears exactly in RESP.
               if (wait_done) begin
                  if (owner_q) begin
                     core_rvalid_o <= 1'b1;
                     core_rdata_o  <= mem_rdata_i;
                  end else if (!host_abort_q && wbs_cyc_i) begin
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= mem_rdata_i;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tjrpu_mem_arbiter.sv
// tb/tb_tjrpu_mem_arbiter.sv - directed bench for tjrpu_mem_arbiter at MEM_LAT 1 and 3
module tb_tjrpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, dat = '0;
   logic        creq = 1'b0, cwe = 1'b0;
   logic [3:0]  csel = '0;
   logic [9:0]  caddr = '0;
   logic [31:0] cwdata = '0;

   logic        ack1, gnt1, rv1, en1, mwe1;
   logic [31:0] dat1, rdata1, mwdata1, mrdata1;
   logic [3:0]  mmask1;
   logic [9:0]  maddr1;
   logic        ack3, gnt3, rv3, en3, mwe3;
   logic [31:0] dat3, rdata3, mwdata3, mrdata3;
   logic [3:0]  mmask3;
   logic [9:0]  maddr3;

   logic [31:0] mem1 [0:1023];
   logic [31:0] mem3 [0:1023];
   logic [31:0] rd1;
   logic [31:0] p3 [0:2];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   tjrpu_mem_arbiter #(.ADDR_W(10), .MEM_LAT(1)) dut1 (
      .wb_clk_i(clk), .wb_rst_n(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
      .core_req_i(creq), .core_we_i(cwe), .core_sel_i(csel), .core_addr_i(caddr),
      .core_wdata_i(cwdata), .core_gnt_o(gnt1), .core_rvalid_o(rv1), .core_rdata_o(rdata1),
      .mem_en_o(en1), .mem_we_o(mwe1), .mem_wmask_o(mmask1), .mem_addr_o(maddr1),
      .mem_wdata_o(mwdata1), .mem_rdata_i(mrdata1)
   );

   tjrpu_mem_arbiter #(.ADDR_W(10), .MEM_LAT(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_n(rst_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack3), .wbs_dat_o(dat3),
      .core_req_i(creq), .core_we_i(cwe), .core_sel_i(csel), .core_addr_i(caddr),
      .core_wdata_i(cwdata), .core_gnt_o(gnt3), .core_rvalid_o(rv3), .core_rdata_o(rdata3),
      .mem_en_o(en3), .mem_we_o(mwe3), .mem_wmask_o(mmask3), .mem_addr_o(maddr3),
      .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3)
   );

   // Memory models: one-cycle synchronous RAM, and a three-cycle pipelined RAM.
   always @(posedge clk) begin
      if (en1) begin
         for (int b = 0; b < 4; b++)
            if (mwe1 && mmask1[b]) mem1[maddr1][b*8 +: 8] <= mwdata1[b*8 +: 8];
         rd1 <= mem1[maddr1];
      end
      if (en3) begin
         for (int b = 0; b < 4; b++)
            if (mwe3 && mmask3[b]) mem3[maddr3][b*8 +: 8] <= mwdata3[b*8 +: 8];
      end
      p3[0] <= mem3[maddr3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign mrdata1 = rd1;
   assign mrdata3 = p3[2];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic host_go(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
   endtask

   task automatic host_stop();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wait_ack(input bit use3, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(use3 ? ack3 : ack1) && n < 20);
   endtask

   task automatic host_read(input bit use3, input logic [31:0] a, output logic [31:0] d,
                            output int n);
      host_go(1'b0, a, 32'h0, 4'hF);
      wait_ack(use3, n);
      d = use3 ? dat3 : dat1;
      host_stop();
      tick();
   endtask

   task automatic core_rw(input logic w, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int ng, output int nv);
      creq = 1'b1; cwe = w; caddr = a; cwdata = d; csel = s;
      ng = 0; nv = 0;
      for (int i = 1; i <= 20 && nv == 0; i++) begin
         tick();
         if (gnt1) begin
            ng = i;
            creq = 1'b0;
         end
         if (rv1) nv = i;
      end
      creq = 1'b0;
      tick();
   endtask

   initial begin
      int n, ng, nv, cnt, t_ack, t_cgnt;
      logic [31:0] d;
      logic [5:0] order;
      logic re, seen;

      // Reset state
      tick(); tick();
      chk("rst_pulses", {28'h0, ack1, gnt1, rv1, en1}, 32'h0);
      chk("rst_wbs_dat", dat1, 32'h0);
      chk("rst_core_rdata", rdata1, 32'h0);
      chk("rst_mem_fields", {17'h0, mwe1, mmask1, maddr1}, 32'h0);
      rst_n = 1'b1;
      tick();

      // 1. Host write then read back
      host_go(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
      tick();
      chk("t1_mem_en", {31'h0, en1}, 32'h1);
      chk("t1_mem_we", {31'h0, mwe1}, 32'h1);
      chk("t1_mem_addr", {22'h0, maddr1}, 32'h4);
      chk("t1_mem_wmask", {28'h0, mmask1}, 32'hF);
      chk("t1_mem_wdata", mwdata1, 32'hDEAD_BEEF);
      wait_ack(1'b0, n);
      chk("t1_wr_ack_lat", n, 32'd2);
      host_stop();
      tick();
      chk("t1_ack_pulse", {31'h0, ack1}, 32'h0);
      host_read(1'b0, 32'h3000_0010, d, n);
      chk("t1_rd_lat", n, 32'd3);
      chk("t1_rd_data", d, 32'hDEAD_BEEF);
      chk("t1_dat_hold", dat1, 32'hDEAD_BEEF);

      // 2. Core read
      core_rw(1'b0, 10'd4, 32'h0, 4'h0, ng, nv);
      chk("t2_gnt_lat", ng, 32'd1);
      chk("t2_rvalid_lat", nv, 32'd3);
      chk("t2_rdata", rdata1, 32'hDEAD_BEEF);

      // 3. Contention straight out of reset; both stay active for six accesses
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      host_go(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      creq = 1'b1; cwe = 1'b0; caddr = 10'd4;
      order = '0; cnt = 0; t_ack = -1; t_cgnt = -1; re = 1'b0;
      for (int i = 1; i <= 40 && cnt < 6; i++) begin
         tick();
         if (ack1) begin
            host_stop();
            re = 1'b1;
            if (t_ack < 0) t_ack = i;
         end else if (re) begin
            host_go(1'b0, 32'h3000_0010, 32'h0, 4'hF);
            re = 1'b0;
         end
         if (en1) begin
            order[cnt] = gnt1;
            cnt++;
         end
         if (gnt1 && t_cgnt < 0) t_cgnt = i;
      end
      host_stop();
      creq = 1'b0;
      repeat (5) tick();
      chk("t3_grant_count", cnt, 32'd6);
      chk("t3_grant_order", {26'h0, order}, 32'h2A);
      chk("t3_first_ack", t_ack, 32'd3);
      chk("t3_core_gnt", t_cgnt, 32'd5);

      // 4. Byte-masked core write, zero-mask host write
      core_rw(1'b1, 10'd4, 32'h0000_AB00, 4'b0010, ng, nv);
      chk("t4_wr_rvalid_lat", nv, 32'd3);
      host_read(1'b0, 32'h3000_0010, d, n);
      chk("t4_masked_data", d, 32'hDEAD_ABEF);
      host_go(1'b1, 32'h3000_0010, 32'h1234_5678, 4'h0);
      tick();
      chk("t4_zero_mask_issue", {27'h0, en1, mmask1}, 32'h10);
      wait_ack(1'b0, n);
      chk("t4_zero_mask_ack", n, 32'd2);
      host_stop();
      tick();
      host_read(1'b0, 32'h3000_0010, d, n);
      chk("t4_unchanged", d, 32'hDEAD_ABEF);

      // 5. Host abandons a write during WAIT
      host_go(1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'hF);
      tick();
      tick();
      host_stop();
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen = seen | ack1;
      end
      chk("t5_no_ack", {31'h0, seen}, 32'h0);
      core_rw(1'b0, 10'd8, 32'h0, 4'h0, ng, nv);
      chk("t5_core_gnt_lat", ng, 32'd1);
      chk("t5_core_rv_lat", nv, 32'd3);
      chk("t5_core_data", rdata1, 32'hCAFE_F00D);

      // 6. MEM_LAT = 3 instance, including reset during WAIT
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      host_go(1'b1, 32'h3000_0014, 32'h5A5A_1234, 4'hF);
      wait_ack(1'b1, n);
      chk("t6_wr_lat", n, 32'd5);
      host_stop();
      tick();
      host_read(1'b1, 32'h3000_0014, d, n);
      chk("t6_rd_lat", n, 32'd5);
      chk("t6_rd_data", d, 32'h5A5A_1234);
      host_go(1'b0, 32'h3000_0014, 32'h0, 4'hF);
      tick();
      chk("t6_issue_en", {31'h0, en3}, 32'h1);
      tick();
      rst_n = 1'b0;
      host_stop();
      #1;
      chk("t6_rst_pulses", {28'h0, ack3, gnt3, rv3, en3}, 32'h0);
      chk("t6_rst_wbs_dat", dat3, 32'h0);
      chk("t6_rst_mem_fields", {17'h0, mwe3, mmask3, maddr3}, 32'h0);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen = seen | ack3 | rv3;
      end
      chk("t6_no_partial_resp", {31'h0, seen}, 32'h0);
      host_read(1'b1, 32'h3000_0014, d, n);
      chk("t6_post_rst_lat", n, 32'd5);
      chk("t6_post_rst_data", d, 32'h5A5A_1234);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
